// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   pc_sel_e          : next-PC source selector driven by the control path
//   fetch_state_e     : fetch FSM state (FETCH / HOLD)
//   NOP_INST          : bubble instruction, addi x0,x0,0
//   fetch_to_decode_t : IF/DEC pipeline register contents
package fetch_stage_pkg;

  localparam int          PC_W     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    PC_4   = 3'd0,
    PC_BR  = 3'd1,
    PC_J   = 3'd2,
    PC_JR  = 3'd3,
    PC_EXC = 3'd4
  } pc_sel_e;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
    logic            valid;
  } fetch_to_decode_t;

endpackage

// File: rtl/fetch_stage_pc_gen.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   i_pc          : current fetch PC
//   i_pc_sel      : pc_sel_e source (5..7 fall back to PC_4)
//   i_br_target   : branch target
//   i_jmp_target  : jal target
//   i_jalr_target : jalr target (low two bits are cleared here)
//   i_exc_target  : exception vector
//   o_pc_plus4    : i_pc + 4, wrapping at 2^XLEN
//   o_redirect_pc : target chosen by i_pc_sel
//   o_redirect    : i_pc_sel selects something other than PC+4
module fetch_pc_gen
  import fetch_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [2:0]      i_pc_sel,
  input  logic [XLEN-1:0] i_br_target,
  input  logic [XLEN-1:0] i_jmp_target,
  input  logic [XLEN-1:0] i_jalr_target,
  input  logic [XLEN-1:0] i_exc_target,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_redirect
);

  // Natural truncation of the adder gives the 2^XLEN wrap.
  assign o_pc_plus4 = i_pc + XLEN'(4);

  always_comb begin
    o_redirect_pc = o_pc_plus4;
    o_redirect    = 1'b0;
    case (i_pc_sel)
      PC_BR: begin
        o_redirect_pc = i_br_target;
        o_redirect    = 1'b1;
      end
      PC_J: begin
        o_redirect_pc = i_jmp_target;
        o_redirect    = 1'b1;
      end
      PC_JR: begin
        o_redirect_pc = {i_jalr_target[XLEN-1:2], 2'b00};
        o_redirect    = 1'b1;
      end
      PC_EXC: begin
        o_redirect_pc = i_exc_target;
        o_redirect    = 1'b1;
      end
      default: begin
        // PC_4 and the reserved encodings both advance sequentially.
        o_redirect_pc = o_pc_plus4;
        o_redirect    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage feeding the decode stage.
// Owns the fetch PC, issues instruction memory requests, registers the
// returned word into the IF/DEC register and applies redirects, kills and
// stalls from the control path. A single-entry hold buffer keeps a fetched
// word while decode is stalled.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   pc_sel, *_target             : next-PC source and redirect targets
//   if_kill                      : squash the instruction now in fetch
//   dec_stall                    : decode cannot accept an instruction
//   cmiss_stall                  : memory miss, whole stage freezes
//   imem_req_valid/addr          : instruction request (addr = fetch PC)
//   imem_res_valid/data          : same-cycle instruction response
//   dec_inst, dec_pc, dec_valid  : IF/DEC pipeline register
//   fetch_count, kill_count      : delivered / squashed instruction counters
//   dbg_state                    : fetch FSM state (fetch_state_e)
//
// Handshake: the stage has no back-pressure on memory; a response is
// consumed on any clock edge where imem_res_valid=1, cmiss_stall=0 and the
// FSM is in FETCH. Decode accepts dec_* on every edge with dec_stall=0.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jmp_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] exc_target,
  input  logic            if_kill,
  input  logic            dec_stall,
  input  logic            cmiss_stall,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_res_valid,
  input  logic [31:0]     imem_res_data,
  output logic [31:0]     dec_inst,
  output logic [XLEN-1:0] dec_pc,
  output logic            dec_valid,
  output logic [31:0]     fetch_count,
  output logic [31:0]     kill_count,
  output logic            dbg_state
);

  logic [XLEN-1:0]  r_pc;
  fetch_state_e     r_state;
  logic [31:0]      r_hold;
  logic             r_hold_valid;
  fetch_to_decode_t r_dec;
  logic [31:0]      r_fetch_count;
  logic [31:0]      r_kill_count;

  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_redirect_pc;
  logic             w_redirect;
  logic             w_discard;

  fetch_pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .i_pc          (r_pc),
    .i_pc_sel      (pc_sel),
    .i_br_target   (br_target),
    .i_jmp_target  (jmp_target),
    .i_jalr_target (jalr_target),
    .i_exc_target  (exc_target),
    .o_pc_plus4    (w_pc_plus4),
    .o_redirect_pc (w_redirect_pc),
    .o_redirect    (w_redirect)
  );

  // A redirect throws away whatever real instruction the stage holds this
  // cycle: the live response in FETCH, or the buffered word in HOLD.
  assign w_discard = (r_state == ST_FETCH) ? imem_res_valid : r_hold_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_state       <= ST_FETCH;
      r_hold        <= NOP_INST;
      r_hold_valid  <= 1'b0;
      r_dec.inst    <= NOP_INST;
      r_dec.pc      <= '0;
      r_dec.valid   <= 1'b0;
      r_fetch_count <= '0;
      r_kill_count  <= '0;
    end else if (cmiss_stall) begin
      // Whole stage frozen.
    end else if (w_redirect) begin
      r_pc         <= w_redirect_pc;
      r_state      <= ST_FETCH;
      r_hold_valid <= 1'b0;
      r_dec.inst   <= NOP_INST;
      r_dec.valid  <= 1'b0;
      if (w_discard) r_kill_count <= r_kill_count + 32'd1;
    end else if (r_state == ST_FETCH) begin
      if (imem_res_valid) begin
        if (!dec_stall) begin
          r_dec.pc <= r_pc;
          r_pc     <= w_pc_plus4;
          if (if_kill) begin
            r_dec.inst   <= NOP_INST;
            r_dec.valid  <= 1'b0;
            r_kill_count <= r_kill_count + 32'd1;
          end else begin
            r_dec.inst    <= imem_res_data;
            r_dec.valid   <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
          end
        end else begin
          // Park the word; a kill here just marks it as a bubble.
          r_hold       <= imem_res_data;
          r_hold_valid <= !if_kill;
          r_state      <= ST_HOLD;
        end
      end else begin
        r_dec.inst  <= NOP_INST;
        r_dec.valid <= 1'b0;
      end
    end else begin
      if (!dec_stall) begin
        r_dec.inst  <= r_hold_valid ? r_hold : NOP_INST;
        r_dec.valid <= r_hold_valid;
        r_dec.pc    <= r_pc;
        r_pc        <= w_pc_plus4;
        r_state     <= ST_FETCH;
        if (r_hold_valid) r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  // Requests continue in HOLD: cmiss_stall depends on the response, so
  // dropping the request could freeze the stage forever.
  assign imem_req_valid = !reset;
  assign imem_req_addr  = r_pc;
  assign dec_inst       = r_dec.inst;
  assign dec_pc         = r_dec.pc;
  assign dec_valid      = r_dec.valid;
  assign fetch_count    = r_fetch_count;
  assign kill_count     = r_kill_count;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  pc_sel;
  logic [31:0] br_target, jmp_target, jalr_target, exc_target;
  logic        if_kill, dec_stall, cmiss_stall, res_en;

  // DUT A: RESET_PC = 0
  logic        a_req_valid, a_dec_valid, a_state;
  logic [31:0] a_req_addr, a_res_data, a_dec_inst, a_dec_pc, a_fc, a_kc;
  // DUT B: RESET_PC = FFFF_FFFC (wrap check)
  logic        b_req_valid, b_dec_valid, b_state;
  logic [31:0] b_req_addr, b_res_data, b_dec_inst, b_dec_pc, b_fc, b_kc;

  // Instruction memory model: ADDI x1,x0,(addr>>2)
  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return {addr[13:2], 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  assign a_res_data = inst_of(a_req_addr);
  assign b_res_data = inst_of(b_req_addr);

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .pc_sel(pc_sel),
    .br_target(br_target), .jmp_target(jmp_target),
    .jalr_target(jalr_target), .exc_target(exc_target),
    .if_kill(if_kill), .dec_stall(dec_stall), .cmiss_stall(cmiss_stall),
    .imem_req_valid(a_req_valid), .imem_req_addr(a_req_addr),
    .imem_res_valid(res_en), .imem_res_data(a_res_data),
    .dec_inst(a_dec_inst), .dec_pc(a_dec_pc), .dec_valid(a_dec_valid),
    .fetch_count(a_fc), .kill_count(a_kc), .dbg_state(a_state)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset), .pc_sel(pc_sel),
    .br_target(br_target), .jmp_target(jmp_target),
    .jalr_target(jalr_target), .exc_target(exc_target),
    .if_kill(if_kill), .dec_stall(dec_stall), .cmiss_stall(cmiss_stall),
    .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr),
    .imem_res_valid(res_en), .imem_res_data(b_res_data),
    .dec_inst(b_dec_inst), .dec_pc(b_dec_pc), .dec_valid(b_dec_valid),
    .fetch_count(b_fc), .kill_count(b_kc), .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {pc, inst} of each instruction decode should see
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the request, predict delivery, clock once, compare decode output.
  task automatic fetch_cycle();
    logic [63:0] e;
    chk("req_addr", a_req_addr, exp_pc);
    exp_q.push_back({exp_pc, inst_of(exp_pc)});
    step();
    exp_pc = exp_pc + 32'd4;
    chk("dec_valid", a_dec_valid, 1);
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dec_pc", a_dec_pc, e[63:32]);
      chk("dec_inst", a_dec_inst, e[31:0]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] e;
    reset = 1'b1; pc_sel = PC_4; if_kill = 0; dec_stall = 0; cmiss_stall = 0; res_en = 0;
    br_target = '0; jmp_target = '0; jalr_target = '0; exc_target = '0;
    step(); step();

    // Reset state
    chk("rst_req_valid", a_req_valid, 0);
    chk("rst_addr", a_req_addr, 32'h0);
    chk("rst_dec_inst", a_dec_inst, 32'h13);
    chk("rst_dec_pc", a_dec_pc, 32'h0);
    chk("rst_dec_valid", a_dec_valid, 0);
    chk("rst_counts", {a_fc, a_kc}, 64'h0);
    chk("rst_state", a_state, ST_FETCH);
    reset = 1'b0;
    #1;
    chk("req_valid", a_req_valid, 1);

    // Plain streaming
    res_en = 1; exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) fetch_cycle();
    chk("fetch_count_3", a_fc, 3);

    // Decode stall with a valid response: hold, then release
    dec_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_state", a_state, ST_HOLD);
      chk("hold_pc", a_req_addr, 32'hC);
      chk("hold_dec", {a_dec_pc, a_dec_inst}, {32'h8, inst_of(32'h8)});
    end
    dec_stall = 0;
    exp_q.push_back({32'hC, inst_of(32'hC)});
    step();
    e = exp_q.pop_front();
    chk("rel_dec", {a_dec_pc, a_dec_inst}, e);
    chk("rel_valid", a_dec_valid, 1);
    chk("rel_next_addr", a_req_addr, 32'h10);
    chk("rel_state", a_state, ST_FETCH);
    chk("rel_fc", a_fc, 4);

    // Killed while stalling: released as a bubble, not counted as a kill
    dec_stall = 1; if_kill = 1; step();
    if_kill = 0; step();
    dec_stall = 0; step();
    chk("khold_dec", {a_dec_pc, a_dec_inst}, {32'h10, 32'h13});
    chk("khold_valid", a_dec_valid, 0);
    chk("khold_counts", {a_fc, a_kc}, {32'd4, 32'd0});
    chk("khold_addr", a_req_addr, 32'h14);

    // Kill in FETCH
    if_kill = 1; step(); if_kill = 0;
    chk("kill_dec", {a_dec_pc, a_dec_inst}, {32'h14, 32'h13});
    chk("kill_valid", a_dec_valid, 0);
    chk("kill_kc", a_kc, 1);
    chk("kill_addr", a_req_addr, 32'h18);

    // JR redirect while in HOLD discards the held word
    dec_stall = 1; step();
    chk("jr_pre_state", a_state, ST_HOLD);
    pc_sel = PC_JR; jalr_target = 32'h103; step();
    pc_sel = PC_4; dec_stall = 0;
    chk("jr_addr", a_req_addr, 32'h100);
    chk("jr_dec", {a_dec_valid, a_dec_inst}, {1'b0, 32'h13});
    chk("jr_kc", a_kc, 2);
    chk("jr_state", a_state, ST_FETCH);

    // Memory miss freeze with disturbing inputs
    exp_pc = 32'h100;
    fetch_cycle();
    cmiss_stall = 1; pc_sel = PC_BR; br_target = 32'h500; if_kill = 1;
    for (int i = 0; i < 5; i++) step();
    chk("cm_addr", a_req_addr, 32'h104);
    chk("cm_dec", {a_dec_pc, a_dec_inst}, {32'h100, inst_of(32'h100)});
    chk("cm_valid", a_dec_valid, 1);
    chk("cm_counts", {a_fc, a_kc}, {32'd5, 32'd2});
    chk("cm_state", a_state, ST_FETCH);
    cmiss_stall = 0; pc_sel = PC_4; if_kill = 0;
    fetch_cycle(); fetch_cycle();
    chk("cm_resume_fc", a_fc, 7);

    // Other redirect sources
    pc_sel = PC_J; jmp_target = 32'h200; step();
    chk("j_addr", a_req_addr, 32'h200);
    chk("j_kc", a_kc, 3);
    res_en = 0; pc_sel = PC_EXC; exc_target = 32'h300; step();
    chk("exc_addr", a_req_addr, 32'h300);
    chk("exc_kc_no_resp", a_kc, 3);
    pc_sel = PC_4; step();
    chk("noresp_addr", a_req_addr, 32'h300);
    chk("noresp_valid", a_dec_valid, 0);
    res_en = 1; pc_sel = 3'd6; exp_pc = 32'h300;
    fetch_cycle();
    pc_sel = PC_BR; br_target = 32'h400; step();
    pc_sel = PC_4;
    chk("br_addr", a_req_addr, 32'h400);
    chk("br_kc", a_kc, 4);

    // Reset during HOLD with a branch pending
    dec_stall = 1; step();
    chk("rh_pre_state", a_state, ST_HOLD);
    reset = 1; pc_sel = PC_BR; br_target = 32'h700; step();
    chk("rh_addr", a_req_addr, 32'h0);
    chk("rh_dec", {a_dec_valid, a_dec_inst}, {1'b0, 32'h13});
    chk("rh_counts", {a_fc, a_kc}, 64'h0);
    chk("rh_state", a_state, ST_FETCH);
    reset = 0; pc_sel = PC_4; dec_stall = 0;

    // PC+4 wrap on the high reset vector instance
    chk("wrap_addr0", b_req_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr1", b_req_addr, 32'h0);
    chk("wrap_dec0", {b_dec_valid, b_dec_pc}, {1'b1, 32'hFFFF_FFFC});
    step();
    chk("wrap_dec1", {b_dec_valid, b_dec_pc, b_dec_inst}, {1'b1, 32'h0, inst_of(32'h0)});
    chk("wrap_fc", b_fc, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
